// File: rtl/alu_scheduler.sv
// Two-requester ALU front end: round-robin arbitration, one-cycle ALU ops,
// an 8-cycle shift-add multiplier, and a held response slot.
module alu_scheduler (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [7:0]  req0_a,
   input  logic [7:0]  req0_b,
   input  logic [3:0]  req0_sel,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [7:0]  req1_a,
   input  logic [7:0]  req1_b,
   input  logic [3:0]  req1_sel,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [15:0] rsp_data,
   output logic        rsp_err,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

   state_t      state_q, state_d;
   logic        ptr_q, ptr_d;
   logic        id_q, id_d;
   logic [7:0]  a_q, a_d;
   logic [7:0]  b_q, b_d;
   logic [3:0]  sel_q, sel_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] acc_q, acc_d;
   logic [15:0] rsp_data_q, rsp_data_d;
   logic        rsp_err_q, rsp_err_d;
   logic        rsp_id_q, rsp_id_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic        busy_q, busy_d;

   logic        grant_id;
   logic [15:0] alu_res;
   logic        alu_err;
   logic [15:0] partial;

   // The pointer only breaks ties; a lone valid requester always wins.
   assign grant_id   = (req0_valid && req1_valid) ? ptr_q : req1_valid;
   assign req0_ready = !rst && (state_q == IDLE) && req0_valid && !grant_id;
   assign req1_ready = !rst && (state_q == IDLE) && req1_valid && grant_id;

   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      case (sel_q)
         4'b0000: alu_res = {7'b0, {1'b0, a_q} + {1'b0, b_q}};
         4'b0001: alu_res = {8'b0, a_q - b_q};
         4'b0011: begin
            if (b_q == 8'd0) begin
               alu_res = 16'h00FF;
               alu_err = 1'b1;
            end else begin
               alu_res = {8'b0, a_q / b_q};
            end
         end
         4'b0100: alu_res = {8'b0, a_q[6:0], 1'b0};
         4'b0101: alu_res = {9'b0, a_q[7:1]};
         4'b0110: alu_res = {8'b0, a_q[6:0], a_q[7]};
         4'b0111: alu_res = {8'b0, a_q[0], a_q[7:1]};
         4'b1000: alu_res = {8'b0, a_q & b_q};
         4'b1001: alu_res = {8'b0, a_q | b_q};
         4'b1010: alu_res = {8'b0, a_q ^ b_q};
         4'b1011: alu_res = {8'b0, ~(a_q | b_q)};
         4'b1100: alu_res = {8'b0, ~(a_q & b_q)};
         4'b1101: alu_res = {8'b0, ~(a_q ^ b_q)};
         4'b1110: alu_res = {15'b0, a_q > b_q};
         4'b1111: alu_res = {15'b0, a_q == b_q};
         default: alu_res = '0;
      endcase
   end

   // One multiplier bit per cycle, LSB first, weighted by the iteration count.
   assign partial = b_q[cnt_q] ? ({8'b0, a_q} << cnt_q) : 16'd0;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      a_d         = a_q;
      b_d         = b_q;
      sel_d       = sel_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      rsp_id_d    = rsp_id_q;
      rsp_valid_d = rsp_valid_q;
      case (state_q)
         IDLE: begin
            if (req0_ready || req1_ready) begin
               id_d    = req1_ready;
               a_d     = req1_ready ? req1_a : req0_a;
               b_d     = req1_ready ? req1_b : req0_b;
               sel_d   = req1_ready ? req1_sel : req0_sel;
               ptr_d   = !req1_ready;
               cnt_d   = 3'd0;
               acc_d   = 16'd0;
               state_d = ((req1_ready ? req1_sel : req0_sel) == 4'b0010) ? MUL : EXEC;
            end
         end
         EXEC: begin
            rsp_data_d  = alu_res;
            rsp_err_d   = alu_err;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         MUL: begin
            acc_d = acc_q + partial;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               rsp_data_d  = acc_q + partial;
               rsp_err_d   = 1'b0;
               rsp_id_d    = id_q;
               rsp_valid_d = 1'b1;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         id_q        <= 1'b0;
         a_q         <= 8'd0;
         b_q         <= 8'd0;
         sel_q       <= 4'd0;
         cnt_q       <= 3'd0;
         acc_q       <= 16'd0;
         rsp_data_q  <= 16'd0;
         rsp_err_q   <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         rsp_id_q    <= rsp_id_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_id    = rsp_id_q;
   assign busy      = busy_q;

endmodule

// File: doc/alu_scheduler.md
ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 Parameters: none; the datapath width is fixed at 8-bit operands and a 16-bit result.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  8 each  requester 0 operands.
REQ-007 req0_sel  input  4  requester 0 opcode, using the team ALU encoding.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_sel  same as REQ-004..007  requester 1.
REQ-009 rsp_valid  output  1  a result is presented.
REQ-010 rsp_ready  input  1  the consumer takes the result this cycle.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 rsp_data  output  16  result value.
REQ-013 rsp_err  output  1  the result is an error substitute (divide by zero).
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, EXEC, MUL and RESP.
REQ-016 Arbitration: in IDLE, a grant SHALL go to the only valid requester; if both are valid, the grant SHALL follow a round-robin pointer (initial value 0).
REQ-017 The pointer SHALL flip to the non-granted requester on each accept.
REQ-018 reqN_ready SHALL be driven combinationally, and only when state==IDLE and N is granted; at most one ready SHALL be high per cycle.
REQ-019 Accept occurs on an edge where reqN_valid && reqN_ready; at that edge a, b, sel and the id SHALL be captured.
REQ-020 After accept the next state SHALL be MUL when sel==4'b0010, otherwise EXEC.
REQ-021 Requesters SHALL hold valid and operands stable until ready.
REQ-022 A requester's valid dropping before ready SHALL be legal, with no side effect.
REQ-023 EXEC SHALL last one cycle; at its exit edge the result SHALL be registered and the state SHALL go to RESP. Response latency is therefore 1 cycle after the accept edge.
REQ-024 Opcodes evaluated in EXEC:
- 0000: A+B, 9-bit sum with carry in bit 8.
- 0001: A-B, 8-bit result zero-extended.
- 0011: A/B.
- 0100: A<<1. 0101: A>>1.
- 0110: rotate left. 0111: rotate right.
- 1000: AND. 1001: OR. 1010: XOR. 1011: NOR. 1100: NAND. 1101: XNOR.
- 1110: A>B gives 1, otherwise 0. 1111: A==B gives 1, otherwise 0.
- All 8-bit results SHALL be zero-extended to 16 bits.
REQ-025 Divide by zero (sel 0011, B==0) SHALL return rsp_data=16'h00FF with rsp_err=1; rsp_err SHALL be 0 for all other operations.
REQ-026 MUL SHALL compute the unsigned 16-bit product A*B by shift-add, one multiplier bit per cycle, LSB first, using a 3-bit iteration counter.
REQ-027 MUL SHALL last exactly 8 cycles, then go to RESP; response latency is 8 cycles after the accept edge, regardless of operand values.
REQ-028 In RESP, rsp_valid=1 and rsp_data/rsp_id/rsp_err SHALL stay stable until rsp_valid && rsp_ready.
REQ-029 On that handshake edge the state SHALL return to IDLE; there SHALL be no accept in the same cycle (throughput at most 1 op per 3 cycles).
REQ-030 While rsp_ready stays low, RESP SHALL hold indefinitely and both readies SHALL stay 0.
REQ-031 rsp_valid SHALL be 0 in every state except RESP.
REQ-032 Pending requests SHALL never be dropped or reordered; each accepted op SHALL produce exactly one response.

Reset
REQ-033 While rst=1 at an edge, the block SHALL go to: state=IDLE, pointer=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0, iteration counter=0; both readies SHALL be 0 during reset.
REQ-034 Reset asserted in EXEC, MUL or RESP SHALL abandon the operation with no response; the first accept is possible in the cycle after rst deasserts.

Verification
REQ-035 Req0 only, sel=0000, A=8'hF0, B=8'h20, rsp_ready=1 -> accept edge k; rsp_valid at edge k+1 with data=16'h0110, id=0, err=0.
REQ-036 Req1, sel=0010, A=8'hFF, B=8'hFF -> rsp_valid exactly 8 cycles after accept, data=16'hFE01, id=1.
REQ-037 Both valid continuously, sel=1010 on each, rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0; never two readies in the same cycle.
REQ-038 sel=0011, A=8'h40, B=0 -> data=16'h00FF, err=1; then A=8'h40, B=8'h03 -> data=16'h0015, err=0.
REQ-039 rsp_ready held low for 5 cycles in RESP -> rsp_* stable, readies 0; single handshake on release; IDLE next.
REQ-040 rst pulsed during MUL cycle 4 -> no rsp_valid; all outputs at reset values; a new op after reset completes correctly.
